// File: rtl/opacc_tile_seq.sv
// Outer-product accumulator tile: C[ML][VL] is loaded or zeroed, then updated by K beats of A x B, then drained row by row.
// Ports: cmd (k/zero/sub) handshake, C row input, A/B beat input, backpressured C row output, busy.
module opacc_tile_seq #(
  parameter int XLEN = 64,
  parameter int VL   = 2,
  parameter int ML   = 2,
  parameter int KW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [KW-1:0]      cmd_k,
  input  logic               cmd_zero,
  input  logic               cmd_sub,
  input  logic               c_in_valid,
  output logic               c_in_ready,
  input  logic [VL*XLEN-1:0] c_in,
  input  logic               ab_valid,
  output logic               ab_ready,
  input  logic [ML*XLEN-1:0] a_in,
  input  logic [VL*XLEN-1:0] b_in,
  output logic               c_out_valid,
  input  logic               c_out_ready,
  output logic [VL*XLEN-1:0] c_out,
  output logic               c_out_last,
  output logic               busy
);

  localparam int RW = (ML > 1) ? $clog2(ML) : 1;

  typedef enum logic [1:0] {
    IDLE, LOAD_C, ACC, DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [KW-1:0]     rem_q, rem_d;
  logic              sub_q, sub_d;
  logic [XLEN-1:0]   c_q [ML][VL];
  logic [XLEN-1:0]   c_d [ML][VL];
  logic              row_end;

  assign row_end = (row_q == RW'(ML - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      rem_q   <= '0;
      sub_q   <= 1'b0;
      for (int i = 0; i < ML; i++)
        for (int j = 0; j < VL; j++)
          c_q[i][j] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rem_q   <= rem_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rem_d   = rem_q;
    sub_d   = sub_q;
    c_d     = c_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rem_d = cmd_k;
          sub_d = cmd_sub;
          row_d = '0;
          if (cmd_zero) begin
            for (int i = 0; i < ML; i++)
              for (int j = 0; j < VL; j++)
                c_d[i][j] = '0;
            state_d = (cmd_k != '0) ? ACC : DRAIN;
          end else begin
            state_d = LOAD_C;
          end
        end
      end
      LOAD_C: begin
        if (c_in_valid) begin
          for (int j = 0; j < VL; j++)
            c_d[row_q][j] = c_in[j*XLEN +: XLEN];
          if (row_end) begin
            row_d   = '0;
            state_d = (rem_q != '0) ? ACC : DRAIN;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      ACC: begin
        if (ab_valid) begin
          for (int i = 0; i < ML; i++)
            for (int j = 0; j < VL; j++)
              c_d[i][j] = sub_q
                ? c_q[i][j] - a_in[i*XLEN +: XLEN] * b_in[j*XLEN +: XLEN]
                : c_q[i][j] + a_in[i*XLEN +: XLEN] * b_in[j*XLEN +: XLEN];
          rem_d = rem_q - KW'(1);
          if (rem_q == KW'(1))
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (c_out_ready) begin
          if (row_end) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cmd_ready is held low while reset is asserted even though state is IDLE
  always_comb begin
    cmd_ready   = 1'b0;
    c_in_ready  = 1'b0;
    ab_ready    = 1'b0;
    c_out_valid = 1'b0;
    c_out_last  = 1'b0;
    c_out       = '0;
    busy        = 1'b1;
    unique case (state_q)
      IDLE: begin
        cmd_ready = reset;
        busy      = 1'b0;
      end
      LOAD_C: c_in_ready = 1'b1;
      ACC:    ab_ready   = 1'b1;
      DRAIN: begin
        c_out_valid = 1'b1;
        c_out_last  = row_end;
        for (int j = 0; j < VL; j++)
          c_out[j*XLEN +: XLEN] = c_q[row_q][j];
      end
      default: busy = 1'b0;
    endcase
  end

endmodule
